// File: rtl/div_pkg.sv
// Shared definitions for the sequential divide path: state encoding,
// default operand width and the divide-by-zero quotient constant.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] QUO_ONES = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle,
// results registered on entry to FIN together with the done pulse.
module div8_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   dvs_ext_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH+1:0] brw_s;
    logic             restore_s;
    logic [WIDTH-1:0] rem_iter_s;
    logic [WIDTH-1:0] q_iter_s;

    // The shift brings the next dividend bit into a WIDTH+1 bit partial remainder.
    assign rem_sh_s  = {rem_q, q_q[WIDTH-1]};
    assign dvs_ext_s = {1'b0, dvs_q};
    assign brw_s[0]  = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        full_subtractor u_fs (
            .a    (rem_sh_s[i]),
            .b    (dvs_ext_s[i]),
            .bin  (brw_s[i]),
            .diff (diff_s[i]),
            .bout (brw_s[i+1])
        );
    end

    // The difference MSB can only be set together with a borrow, so folding it
    // into the select changes nothing arithmetically.
    assign restore_s  = brw_s[WIDTH+1] | diff_s[WIDTH];
    assign rem_iter_s = restore_s ? rem_sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
    assign q_iter_s   = {q_q[WIDTH-2:0], ~restore_s};

    // Next-state and datapath control for IDLE/CALC/FIN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != {WIDTH{1'b0}}) begin
                        state_d = CALC;
                        dvs_d   = divisor;
                        rem_d   = {WIDTH{1'b0}};
                        q_d     = dividend;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d   = FIN;
                        quo_out_d = QUO_ONES;
                        rem_out_d = dividend;
                        dbz_d     = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = rem_iter_s;
                q_d   = q_iter_s;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = FIN;
                    quo_out_d = q_iter_s;
                    rem_out_d = rem_iter_s;
                    dbz_d     = 1'b0;
                end else begin
                    state_d = CALC;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State, datapath and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_out_q <= {WIDTH{1'b0}};
            rem_out_q <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Scoreboard bench for div8_seq: stimulus pushes expected results computed with
// plain / and %, a negedge monitor pops and compares on every done pulse.
module tb_div8_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        int q;
        int r;
        int dbz;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    div8_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        if (b == 0) begin
            e.q = 255; e.r = a; e.dbz = 1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 0; e.lat = 9;
        end
        e.start_cyc = c;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), e.q);
                    chk("remainder", int'(remainder), e.r);
                    chk("div_by_zero", int'(div_by_zero), e.dbz);
                    chk("done_latency", cyc - e.start_cyc, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // Issue one request at a negedge; returns one cycle later with start low.
    task automatic issue(input int a, input int b);
        wait_idle();
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 8'(b);
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom_range(0, 255));
        divisor  = 8'($urandom_range(0, 255));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_quotient"}, int'(quotient), 0);
        chk({tag, "_remainder"}, int'(remainder), 0);
        chk({tag, "_dbz"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int corner[4];
        int n;
        corner[0] = 0; corner[1] = 1; corner[2] = 254; corner[3] = 255;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero_outputs("reset");

        issue(100, 7);
        issue(255, 1);
        issue(255, 255);
        issue(5, 9);
        issue(42, 0);
        issue(42, 6);

        // 200/3 with ignored 9/9 requests while busy, including the FIN cycle.
        wait_idle();
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        sb.push_back(model(200, 3, cyc));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3 || k == 9) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd9;
            end else begin
                start = 1'b0;
            end
        end

        // Reset in the middle of 100/7: outputs clear at once, no done follows.
        issue(100, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("postreset");
        issue(100, 7);

        foreach (corner[i]) begin
            foreach (corner[j]) begin
                issue(corner[i], corner[j]);
            end
        end

        for (int k = 0; k < 3000; k++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) b = 0;
            else if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 15));
            else b = int'($urandom_range(1, 255));
            issue(a, b);
        end

        n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
